// File: rtl/riscv_mem_pkg.sv
// Shared RV32I memory-access width codes, FSM state type and the access legality check.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    RESP
  } lsu_state_e;

  // Illegal width code for the direction, or address not naturally aligned.
  function automatic logic access_error(input logic we, input logic [2:0] funct3,
                                        input logic [1:0] addr_lo);
    logic err;
    err = 1'b0;
    case (funct3)
      F3_B:         err = 1'b0;
      F3_H:         err = addr_lo[0];
      F3_W:         err = (addr_lo != 2'b00);
      F3_BU, F3_HU: err = we | ((funct3 == F3_HU) & addr_lo[0]);
      default:      err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: load extract/extend and store read-modify-write merge.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [31:0] byte_shift;
  logic [31:0] half_shift;

  always_comb begin
    byte_shift = word >> {addr_lo, 3'b000};
    half_shift = word >> {addr_lo[1], 4'b0000};
    load_data  = '0;
    case (funct3)
      F3_B:    load_data = {{24{byte_shift[7]}}, byte_shift[7:0]};
      F3_H:    load_data = {{16{half_shift[15]}}, half_shift[15:0]};
      F3_W:    load_data = word;
      F3_BU:   load_data = {24'h0, byte_shift[7:0]};
      F3_HU:   load_data = {16'h0, half_shift[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    merge_data = word;
    case (funct3)
      F3_B:    merge_data[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      F3_H:    merge_data[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      F3_W:    merge_data = wdata;
      default: merge_data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: byte/half/word access with sub-word stores done as read-modify-write.
module load_store_unit
  import riscv_mem_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  state, state_next;
  logic [31:0] addr_q, wdata_q, word_q;
  logic [2:0]  funct3_q;
  logic        we_q, err_q;
  logic        accept, req_err;
  logic [31:0] load_data, merge_data;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;
  assign req_err   = access_error(req_we, req_funct3, req_addr[1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      funct3_q <= '0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
        funct3_q <= req_funct3;
        we_q     <= req_we;
        err_q    <= req_err;
      end
      if (state == READ) word_q <= mem_rdata;
    end
  end

  // Full-word stores skip the read; sub-word stores read first so untouched lanes survive.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                         state_next = RESP;
          else if (req_we && req_funct3 == F3_W) state_next = WRITE;
          else                                 state_next = READ;
        end
      end
      READ:    state_next = we_q ? WRITE : RESP;
      WRITE:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .word       (word_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_comb begin
    mem_addr   = {addr_q[31:2], 2'b00};
    mem_we     = (state == WRITE) && !rst;
    mem_wdata  = (state == WRITE) ? merge_data : '0;
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = ((state == RESP) && !err_q && !we_q) ? load_data : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed plus random checking of load_store_unit against a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;

  logic [31:0] tb_mem [16];
  logic [7:0]  ref_mem [64];
  logic [31:0] last_rdata;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr[5:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int access_bytes(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    if (f3 == 3'd2) return 4;
    return 0;
  endfunction

  function automatic logic model_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
    int n;
    n = access_bytes(f3);
    if (n == 0) return 1'b1;
    if (we && f3 > 3'd2) return 1'b1;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int    base, n;
    longint unsigned v;
    base = int'(a[5:0]);
    n    = access_bytes(f3);
    v    = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + ref_mem[base + i];
    if (f3 < 3'd2 && v >= (longint'(1) << (8 * n - 1))) v = v + (longint'(1) << 32) - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int base;
    base = int'(a[5:0]) / 4 * 4;
    return {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
  endfunction

  // Caller is between a falling edge and the next rising edge with the DUT idle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
    logic        exp_err;
    logic [31:0] exp_rdata, exp_word, v;
    int          exp_lat, lat, pulses, base;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    #1;
    check("req_ready", req_ready, 1);
    exp_err   = model_err(we, f3, addr);
    exp_lat   = exp_err ? 1 : ((we && f3 != 3'd2) ? 3 : 2);
    exp_rdata = (!exp_err && !we) ? ref_load(f3, addr) : 32'h0;
    exp_word  = 32'h0;
    if (!exp_err && we) begin
      base = int'(addr[5:0]);
      v    = wdata;
      for (int i = 0; i < access_bytes(f3); i++) begin
        ref_mem[base + i] = v[7:0];
        v = v >> 8;
      end
      exp_word = ref_word(addr);
    end
    lat = 0; pulses = 0;
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (mem_we) begin
        pulses++;
        check("mem_we_cycle", k, exp_lat - 1);
        check("mem_addr", mem_addr, {addr[31:2], 2'b00});
        check("mem_wdata", mem_wdata, exp_word);
      end else check("mem_wdata_idle", mem_wdata, 0);
      if (resp_valid) lat = k;
      else check("rdata_idle", resp_rdata, 0);
    end
    check("latency", lat, exp_lat);
    if (lat != 0) begin
      check("resp_err", resp_err, exp_err);
      check("resp_rdata", resp_rdata, exp_rdata);
    end
    last_rdata = resp_rdata;
    check("we_pulses", pulses, (we && !exp_err) ? 1 : 0);
    @(negedge clk);
    check("resp_pulse_end", resp_valid, 0);
  endtask

  initial begin
    logic [31:0] w;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    last_rdata = '0;
    for (int i = 0; i < 16; i++) begin
      w = (i == 1) ? 32'h8899AABB : $urandom;
      tb_mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[i * 4 + b] = w[8 * b +: 8];
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    rst = 1'b0;

    do_req(1'b0, 3'b000, 32'h6, 32'h0);
    check("lb_0x6", last_rdata, 32'hFFFFFF99);
    do_req(1'b0, 3'b101, 32'h6, 32'h0);
    check("lhu_0x6", last_rdata, 32'h00008899);
    do_req(1'b0, 3'b010, 32'h4, 32'h0);
    check("lw_0x4", last_rdata, 32'h8899AABB);
    do_req(1'b1, 3'b000, 32'h5, 32'h123456CC);
    check("sb_ref_word", ref_word(32'h4), 32'h8899CCBB);
    do_req(1'b0, 3'b010, 32'h4, 32'h0);
    check("lw_after_sb", last_rdata, 32'h8899CCBB);
    do_req(1'b1, 3'b010, 32'h8, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h2, 32'h0);
    do_req(1'b1, 3'b001, 32'h3, 32'h0000FFFF);
    do_req(1'b0, 3'b011, 32'h0, 32'h0);
    do_req(1'b1, 3'b100, 32'h0, 32'h0);

    // Reset lands in the WRITE cycle of an SB; the store must vanish.
    req_we = 1'b1; req_funct3 = 3'b000; req_addr = 32'h4; req_wdata = 32'h55; req_valid = 1'b1;
    #1;
    check("rst_sb_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_write_mem_we", mem_we, 0);
    check("rst_write_resp", resp_valid, 0);
    @(negedge clk);
    check("rst_after_resp", resp_valid, 0);
    check("rst_after_mem_we", mem_we, 0);
    check("rst_after_ready", req_ready, 0);
    rst = 1'b0;
    do_req(1'b0, 3'b010, 32'h4, 32'h0);
    check("lw_after_rst", last_rdata, 32'h8899CCBB);

    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
